// File: rtl/ucsbece154_icache_pkg.sv
// Shared types and derived address-field widths for the instruction cache.
// Consumers import ucsbece154_icache_pkg::* and size their fields from these helpers.
package ucsbece154_icache_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  // OFF: byte-offset width of a line, i.e. bits below the set index.
  function automatic int calc_off_w(input int block_words);
    return 2 + $clog2(block_words);
  endfunction

  function automatic int calc_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int block_words, input int num_sets);
    return 32 - calc_off_w(block_words) - calc_idx_w(num_sets);
  endfunction

endpackage

// File: rtl/ucsbece154_icache_er_if.sv
// Refill bus between the cache (master) and the SDRAM controller (slave).
interface ucsbece154_icache_er_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_ready;

  modport master (output mem_addr, mem_req, input mem_data, mem_ready);
  modport slave  (input mem_addr, mem_req, output mem_data, mem_ready);
endinterface

// File: rtl/ucsbece154_icache_refill.sv
// Refill engine: beat counter, request capture, early-restart detect and deferred
// invalidate. The top module owns the FSM state and the tag/data arrays.
module ucsbece154_icache_refill
  import ucsbece154_icache_pkg::*;
#(
  parameter  int NUM_SETS    = 8,
  parameter  int BLOCK_WORDS = 4,
  localparam int OFF_W       = calc_off_w(BLOCK_WORDS),
  localparam int IDX_W       = calc_idx_w(NUM_SETS),
  localparam int TAG_W       = calc_tag_w(BLOCK_WORDS, NUM_SETS)
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         start,
  input  logic                         active,
  input  logic                         invalidate,
  input  logic [31:0]                  start_addr,
  ucsbece154_icache_er_if.master       mem,
  output logic                         word_ready,
  output logic                         line_done,
  output logic                         clear_all,
  output logic [IDX_W-1:0]             req_index,
  output logic [TAG_W-1:0]             req_tag,
  output logic [BLOCK_WORDS-1:0][31:0] line
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] req_off_q;
  logic [31:OFF_W]  req_blk_q;
  logic             pend_q;
  logic [31:0]      buf_q [BLOCK_WORDS];
  logic             beat;
  logic [1:0]       unused_addr_lsb;

  assign unused_addr_lsb = start_addr[1:0];

  assign beat       = active && mem.mem_ready;
  assign word_ready = beat && (cnt_q == req_off_q);
  assign line_done  = beat && (cnt_q == CNT_W'(BLOCK_WORDS - 1));
  // An invalidate arriving on the completion beat itself must also wipe the new line.
  assign clear_all  = pend_q || invalidate;

  assign req_index    = req_blk_q[OFF_W +: IDX_W];
  assign req_tag      = req_blk_q[31 -: TAG_W];
  assign mem.mem_addr = {req_blk_q, {OFF_W{1'b0}}};
  assign mem.mem_req  = active;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q     <= '0;
      req_off_q <= '0;
      req_blk_q <= '0;
      pend_q    <= 1'b0;
    end else if (start) begin
      cnt_q     <= '0;
      req_off_q <= start_addr[OFF_W-1:2];
      req_blk_q <= start_addr[31:OFF_W];
      pend_q    <= 1'b0;
    end else if (active) begin
      if (beat) cnt_q <= cnt_q + 1'b1;
      if (line_done)       pend_q <= 1'b0;
      else if (invalidate) pend_q <= 1'b1;
    end
  end

  // NOTE: storage arrays are not reset; valid bits alone decide whether contents are used.
  always_ff @(posedge Clk) begin
    if (beat) buf_q[cnt_q] <= mem.mem_data;
  end

  // The last word bypasses the buffer so the line can be written on its arrival edge.
  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) line[i] = buf_q[i];
    line[BLOCK_WORDS-1] = mem.mem_data;
  end

endmodule

// File: rtl/ucsbece154_icache_er.sv
// Set-associative instruction cache with early restart and round-robin replacement.
// Define ICACHE_PERF_EN to add the HitCount/MissCount performance counters.
module ucsbece154_icache_er
  import ucsbece154_icache_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ReadEnable,
  input  logic [31:0] ReadAddress,
  input  logic        Invalidate,
  output logic [31:0] Instruction,
  output logic        Ready,
  output logic        Busy,
  output logic [31:0] MemReadAddress,
  output logic        MemReadRequest,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int OFF_W = calc_off_w(BLOCK_WORDS);
  localparam int IDX_W = calc_idx_w(NUM_SETS);
  localparam int TAG_W = calc_tag_w(BLOCK_WORDS, NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int CNT_W = $clog2(BLOCK_WORDS);

  state_e state_q, state_d;

  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]    rr_q    [NUM_SETS];

  logic [CNT_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [31:0]      hit_word;
  logic             lookup_hit;
  logic             start;
  logic [WAY_W-1:0] victim;
  logic [1:0]       unused_addr_lsb;

  logic                         word_ready, line_done, clear_all;
  logic [IDX_W-1:0]             req_index;
  logic [TAG_W-1:0]             req_tag;
  logic [BLOCK_WORDS-1:0][31:0] line;

  ucsbece154_icache_er_if mem_bus ();

  assign mem_bus.mem_data  = MemDataIn;
  assign mem_bus.mem_ready = MemDataReady;
  assign MemReadAddress    = mem_bus.mem_addr;
  assign MemReadRequest    = mem_bus.mem_req;
  assign Busy              = (state_q == ST_REFILL);

  assign unused_addr_lsb = ReadAddress[1:0];
  assign lk_off = ReadAddress[OFF_W-1:2];
  assign lk_idx = ReadAddress[OFF_W +: IDX_W];
  assign lk_tag = ReadAddress[31 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_word   = data_q[lk_idx][hit_way][lk_off];
  assign lookup_hit = (state_q == ST_IDLE) && ReadEnable && !Invalidate && hit;

  // Lowest invalid way wins; the downward scan leaves the smallest index last.
  always_comb begin
    victim = rr_q[req_index];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_index][w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReadEnable && !Invalidate && !hit) begin
          state_d = ST_REFILL;
          start   = 1'b1;
        end
      end
      ST_REFILL: if (line_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  ucsbece154_icache_refill #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_refill (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .active     (Busy),
    .invalidate (Invalidate),
    .start_addr (ReadAddress),
    .mem        (mem_bus),
    .word_ready (word_ready),
    .line_done  (line_done),
    .clear_all  (clear_all),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .line       (line)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Ready       <= 1'b0;
      Instruction <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      Ready <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (Invalidate) begin
          for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (lookup_hit) begin
          Ready       <= 1'b1;
          Instruction <= hit_word;
        end
      end else begin
        if (word_ready) begin
          Ready       <= 1'b1;
          Instruction <= MemDataIn;
        end
        if (line_done) begin
          rr_q[req_index] <= rr_q[req_index] + 1'b1;
          if (clear_all) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
          end else begin
            valid_q[req_index][victim] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (line_done) begin
      tag_q[req_index][victim] <= req_tag;
      for (int i = 0; i < BLOCK_WORDS; i++) data_q[req_index][victim][i] <= line[i];
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (lookup_hit) HitCount  <= HitCount + 32'd1;
      if (start)      MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154_icache_er.sv
// Self-checking bench: transaction-level cache model, random memory latency,
// directed scenarios and a randomized fetch phase, all compared every cycle.
module tb_ucsbece154_icache_er;

  localparam int S  = 8;
  localparam int W  = 4;
  localparam int BW = 4;

  logic        Clk;
  logic        Reset_n;
  logic        ReadEnable;
  logic [31:0] ReadAddress;
  logic        Invalidate;
  logic [31:0] Instruction;
  logic        Ready;
  logic        Busy;
`ifdef ICACHE_PERF_EN
  logic [31:0] HitCount, MissCount;
`endif

  ucsbece154_icache_er_if mem_if ();

  ucsbece154_icache_er #(.NUM_SETS(S), .NUM_WAYS(W), .BLOCK_WORDS(BW)) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .ReadEnable     (ReadEnable),
    .ReadAddress    (ReadAddress),
    .Invalidate     (Invalidate),
    .Instruction    (Instruction),
    .Ready          (Ready),
    .Busy           (Busy),
    .MemReadAddress (mem_if.mem_addr),
    .MemReadRequest (mem_if.mem_req),
    .MemDataIn      (mem_if.mem_data),
    .MemDataReady   (mem_if.mem_ready)
`ifdef ICACHE_PERF_EN
    ,
    .HitCount       (HitCount),
    .MissCount      (MissCount)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- behavioural cache model ----------------
  bit          m_valid [S][W];
  int unsigned m_tag   [S][W];
  logic [31:0] m_data  [S][W][BW];
  int          m_rr    [S];
  bit          m_refill, m_ready, m_pend;
  logic [31:0] m_instr, m_maddr, m_req;
  int          m_cnt;
  logic [31:0] m_line [BW];
  int          m_hits, m_misses;

  task automatic model_clear_valid();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_valid();
    for (int s = 0; s < S; s++) m_rr[s] = 0;
    m_refill = 0; m_ready = 0; m_pend = 0;
    m_instr = '0; m_maddr = '0; m_cnt = 0;
    m_hits = 0; m_misses = 0;
  endtask

  task automatic model_step();
    int unsigned idx, tag, off;
    int          way, vic;
    m_ready = 0;
    if (!m_refill) begin
      if (Invalidate) model_clear_valid();
      else if (ReadEnable) begin
        idx = (ReadAddress / 16) % S;
        tag = ReadAddress / 128;
        off = (ReadAddress / 4) % BW;
        way = -1;
        for (int w = 0; w < W; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        if (way >= 0) begin
          m_ready = 1;
          m_instr = m_data[idx][way][off];
          m_hits++;
        end else begin
          m_refill = 1;
          m_req    = ReadAddress;
          m_maddr  = ReadAddress & ~32'hF;
          m_cnt    = 0;
          m_pend   = 0;
          m_misses++;
        end
      end
    end else begin
      if (Invalidate) m_pend = 1;
      if (mem_if.mem_ready) begin
        m_line[m_cnt] = mem_if.mem_data;
        if (m_cnt == (m_req / 4) % BW) begin
          m_ready = 1;
          m_instr = mem_if.mem_data;
        end
        if (m_cnt == BW - 1) begin
          idx = (m_req / 16) % S;
          vic = m_rr[idx];
          for (int w = W - 1; w >= 0; w--) if (!m_valid[idx][w]) vic = w;
          m_valid[idx][vic] = 1;
          m_tag[idx][vic]   = m_req / 128;
          for (int i = 0; i < BW; i++) m_data[idx][vic][i] = m_line[i];
          m_rr[idx] = (m_rr[idx] + 1) % W;
          if (m_pend) model_clear_valid();
          m_refill = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) model_reset();
    else          model_step();
  end

  // ---------------- memory responder ----------------
  int resp_cnt;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              resp_cnt = 0;
    else if (mem_if.mem_ready) resp_cnt = (resp_cnt + 1) % BW;
  end

  always begin
    @(negedge Clk);
    #1;
    if (Reset_n && mem_if.mem_req && $urandom_range(0, 3) != 0) begin
      mem_if.mem_ready = 1'b1;
      mem_if.mem_data  = mem_word(mem_if.mem_addr + 32'(4 * resp_cnt));
    end else begin
      mem_if.mem_ready = 1'b0;
      mem_if.mem_data  = $urandom;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          seen_ready;
  logic [31:0] seen_instr;

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      check("ready", {31'b0, Ready}, {31'b0, m_ready});
      check("busy", {31'b0, Busy}, {31'b0, m_refill});
      check("mem_req", {31'b0, mem_if.mem_req}, {31'b0, m_refill});
      if (m_ready)  check("instruction", Instruction, m_instr);
      if (m_refill) check("mem_addr", mem_if.mem_addr, m_maddr);
      if (Ready === 1'b1) begin
        seen_ready = 1;
        seen_instr = Instruction;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic read(input logic [31:0] a, input bit inv);
    ReadAddress = a;
    ReadEnable  = 1'b1;
    Invalidate  = inv;
    cycle();
    ReadEnable  = 1'b0;
    Invalidate  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 200) begin
      cycle();
      n++;
    end
    check("refill_timeout", {31'b0, n < 200}, 32'd1);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, Ready}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    check("rst_instruction", Instruction, 32'd0);
    check("rst_mem_addr", mem_if.mem_addr, 32'd0);
    cycle();
    Reset_n = 1'b1;
    cycle();
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; ReadEnable = 1'b0; ReadAddress = '0; Invalidate = 1'b0;
    mem_if.mem_ready = 1'b0; mem_if.mem_data = '0;
    seen_ready = 0; seen_instr = '0;
    repeat (3) cycle();
    do_reset();

    // cold miss with early restart on word 2
    seen_ready = 0;
    read(32'h48, 0);
    check("cold_busy", {31'b0, Busy}, 32'd1);
    check("cold_mem_addr", mem_if.mem_addr, 32'h40);
    wait_idle();
    check("cold_seen_ready", {31'b0, seen_ready}, 32'd1);
    check("cold_word", seen_instr, mem_word(32'h48));

    // hit on the refilled line
    read(32'h4C, 0);
    check("hit_ready", {31'b0, Ready}, 32'd1);
    check("hit_word", Instruction, mem_word(32'h4C));
    check("hit_no_req", {31'b0, mem_if.mem_req}, 32'd0);

    // fill set 0, then evict way 0 with 0x200
    for (int i = 0; i < 5; i++) begin
      read(32'(i * 32'h80), 0);
      check("evict_fill_miss", {31'b0, Busy}, 32'd1);
      wait_idle();
    end
    read(32'h080, 0);
    check("evict_keep_080", {31'b0, Ready}, 32'd1);
    read(32'h000, 0);
    check("evict_000_miss", {31'b0, Busy}, 32'd1);
    wait_idle();

    // invalidate beats read enable in IDLE
    read(32'h080, 1);
    check("inv_no_ready", {31'b0, Ready}, 32'd0);
    check("inv_no_busy", {31'b0, Busy}, 32'd0);
    read(32'h080, 0);
    check("inv_then_miss", {31'b0, Busy}, 32'd1);
    wait_idle();

    // invalidate during a refill
    seen_ready = 0;
    read(32'h0C4, 0);
    Invalidate = 1'b1;
    cycle();
    Invalidate = 1'b0;
    wait_idle();
    check("midinv_seen_ready", {31'b0, seen_ready}, 32'd1);
    check("midinv_word", seen_instr, mem_word(32'h0C4));
    read(32'h0C4, 0);
    check("midinv_line_miss", {31'b0, Busy}, 32'd1);
    wait_idle();

    // reset after two refill words
    read(32'h300, 0);
    n = 0;
    while (!(m_refill && m_cnt == 2) && n < 200) begin
      cycle();
      n++;
    end
    check("two_words_timeout", {31'b0, n < 200}, 32'd1);
    do_reset();
    read(32'h300, 0);
    check("post_reset_miss", {31'b0, Busy}, 32'd1);
    wait_idle();

    // randomized fetch stream over a few conflicting tags
    for (int c = 0; c < 2000; c++) begin
      if (!Busy)
        ReadAddress = ($urandom_range(0, 5) << 7) | ($urandom_range(0, S - 1) << 4)
                    | ($urandom_range(0, BW - 1) << 2) | $urandom_range(0, 3);
      ReadEnable = 1'($urandom_range(0, 1));
      Invalidate = ($urandom_range(0, 39) == 0);
      cycle();
    end
    ReadEnable = 1'b0;
    Invalidate = 1'b0;
    wait_idle();

`ifdef ICACHE_PERF_EN
    do_reset();
    read(32'h000, 0); wait_idle();
    read(32'h004, 0);
    read(32'h010, 0); wait_idle();
    read(32'h014, 0);
    read(32'h020, 0); wait_idle();
    check("miss_count", MissCount, 32'd3);
    check("hit_count", HitCount, 32'd2);
`endif

    repeat (3) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154_icache_er.md
UCSBECE154_ICACHE_ER -- requirements
Module: ucsbece154_icache_er

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8: sets; power of two, at least 2.
REQ-002 SHALL have parameter NUM_WAYS, default 4: ways per set; power of two, at least 2.
REQ-003 SHALL have parameter BLOCK_WORDS, default 4: 32-bit words per line; power of two, at least 2.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ReadEnable, input, 1 bit: fetch request, sampled only in IDLE.
REQ-007 SHALL have port ReadAddress, input, 32 bits: byte address of the fetch; bits [1:0] ignored.
REQ-008 SHALL have port Invalidate, input, 1 bit: pulse that clears all valid bits (fence.i).
REQ-009 SHALL have port Instruction, output, 32 bits: fetched word, meaningful only while Ready=1.
REQ-010 SHALL have port Ready, output, 1 bit: one-cycle pulse qualifying Instruction.
REQ-011 SHALL have port Busy, output, 1 bit: refill in progress; core holds ReadAddress.
REQ-012 SHALL have port MemReadAddress, output, 32 bits: block-aligned refill address.
REQ-013 SHALL have port MemReadRequest, output, 1 bit: level request, held for the whole refill.
REQ-014 SHALL have port MemDataIn, input, 32 bits: refill word from the SDRAM controller.
REQ-015 SHALL have port MemDataReady, input, 1 bit: MemDataIn valid this cycle.

Function
REQ-016 SHALL decode the address as: word offset [OFF-1:2], OFF = 2 + log2(BLOCK_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
REQ-017 SHALL implement states IDLE and REFILL only.
REQ-018 SHALL, in IDLE on a hit with ReadEnable=1, drive Ready=1 and the hit word on the next edge, with no memory request.
REQ-019 SHALL, in IDLE on a miss with ReadEnable=1, enter REFILL on the next edge with Busy=1, MemReadRequest=1 and MemReadAddress = ReadAddress with the offset bits zeroed.
REQ-020 SHALL accept refill words in ascending order 0..BLOCK_WORDS-1, one per MemDataReady cycle, counted by a log2(BLOCK_WORDS)-bit counter.
REQ-021 SHALL provide early restart: on the edge after the word at the requested offset arrives, Ready=1 and Instruction equals that word; Busy stays 1.
REQ-022 SHALL, on the last word, on the same edge: write the line, tag and valid bit; drop Busy and MemReadRequest; return to IDLE.
REQ-023 SHALL ignore ReadEnable in REFILL; the first lookup after a refill is evaluated in IDLE.
REQ-024 SHALL select the victim as the lowest-index invalid way; if all ways are valid, the per-set round-robin pointer, which advances by one (mod NUM_WAYS) on each refill of that set.
REQ-025 SHALL, on Invalidate in IDLE, clear all valid bits on the next edge; Invalidate takes priority over ReadEnable in the same cycle (no lookup, no Ready).
REQ-026 SHALL, on Invalidate during REFILL, latch it as pending and clear all valid bits, including the refilled line, at refill completion; early restart still delivers its word.
REQ-027 SHALL keep Ready at 0 in every cycle not covered by REQ-018 or REQ-021.

Reset
REQ-028 SHALL, while Reset_n=0, immediately force: state IDLE; Ready, Busy and MemReadRequest = 0; Instruction and MemReadAddress = 0; all valid bits, round-robin pointers, word counter and pending-invalidate flag = 0.
REQ-029 SHALL abandon a refill in progress on reset; no partial line becomes valid.

Configuration
REQ-030 SHALL, with ICACHE_PERF_EN defined, add outputs HitCount and MissCount (32 bits each), which increment on each IDLE hit and each IDLE miss respectively, wrap modulo 2^32, and reset to 0.
REQ-031 SHALL, without ICACHE_PERF_EN, have neither these ports nor the counter logic.

Structure
REQ-032 SHALL place the state enum and the derived-width constants (OFF, index width, tag width) in package ucsbece154_icache_pkg.
REQ-033 SHALL implement the refill counter, early-restart capture and pending-invalidate logic in sub-module ucsbece154_icache_refill; tag/data arrays and hit logic stay in the top module.

Verification (defaults: index bits [6:4], tag bits [31:7])
REQ-034 SHALL cover cold miss: read 0x00000048 -> MemReadAddress=0x00000040; Ready with the 3rd word one edge after the 3rd MemDataReady; Busy falls after the 4th.
REQ-035 SHALL cover hit: read 0x0000004C after REQ-034 -> Ready on the next edge with the 4th word; MemReadRequest stays 0.
REQ-036 SHALL cover eviction: miss on 0x000, 0x080, 0x100, 0x180, then 0x200 -> 0x200 replaces way 0; re-reading 0x000 misses.
REQ-037 SHALL cover invalidate: Invalidate and ReadEnable together in IDLE -> no Ready; the next read of 0x080 misses; Invalidate mid-refill -> word still delivered, then a line miss.
REQ-038 SHALL cover reset mid-refill: Reset_n=0 after 2 words -> outputs 0 immediately; re-reading the same address misses.
REQ-039 SHALL cover counters (with ICACHE_PERF_EN): 3 misses and 2 hits -> MissCount=3, HitCount=2.
